// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryption core: one inverse round per clock with an on-the-fly reversed key schedule.
// Define PRESENT_DECKEY_IN_EN to accept the final round-key register K32 directly and skip key expansion.
module present_decrypt (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable_in,
  input  logic [63:0] ciphertext,
  input  logic [79:0] key,
  output logic [63:0] out,
  output logic        enable_out,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: enable_in is a start request honoured only while busy is low;
  // enable_out is a single-cycle strobe during which out carries the plaintext.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_KEYFWD  = 2'd1,
    S_WHITEN  = 2'd2,
    S_DECRYPT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] st_q, st_d;
  logic [79:0] kreg_q, kreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] out_q, out_d;
  logic        en_out_q, en_out_d;

  logic [79:0] kreg_rev;
  logic [63:0] st_dec;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Forward pLayer sends bit i to 16*i mod 63 (bit 63 fixed); undo it by gathering.
  function automatic logic [63:0] inv_perm(input logic [63:0] s);
    logic [63:0] ip;
    ip = '0;
    for (int j = 0; j < 63; j++) begin
      ip[j] = s[(j * 16) % 63];
    end
    ip[63] = s[63];
    return ip;
  endfunction

  function automatic logic [63:0] inv_round(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] p;
    logic [63:0] q;
    p = inv_perm(s);
    q = '0;
    for (int n = 0; n < 16; n++) begin
      q[n*4 +: 4] = inv_sbox(p[n*4 +: 4]);
    end
    return q ^ rk;
  endfunction

  function automatic logic [79:0] key_rev(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] t;
    t = k;
    t[19:15] = t[19:15] ^ c;
    t[79:76] = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

`ifndef PRESENT_DECKEY_IN_EN
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ c;
    return t;
  endfunction
`endif

  assign kreg_rev = key_rev(kreg_q, cnt_q);
  assign st_dec   = inv_round(st_q, kreg_rev[79:16]);

  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    kreg_d   = kreg_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    en_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_in) begin
          kreg_d = key;
          st_d   = ciphertext;
`ifdef PRESENT_DECKEY_IN_EN
          cnt_d   = 5'd31;
          state_d = S_WHITEN;
`else
          cnt_d   = 5'd1;
          state_d = S_KEYFWD;
`endif
        end
      end
      S_KEYFWD: begin
`ifdef PRESENT_DECKEY_IN_EN
        state_d = S_IDLE;
`else
        kreg_d = key_fwd(kreg_q, cnt_q);
        // cnt saturates at 31 here; WHITEN reloads it anyway.
        if (cnt_q == 5'd31) begin
          state_d = S_WHITEN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
`endif
      end
      S_WHITEN: begin
        st_d    = st_q ^ kreg_q[79:16];
        cnt_d   = 5'd31;
        state_d = S_DECRYPT;
      end
      S_DECRYPT: begin
        st_d   = st_dec;
        kreg_d = kreg_rev;
        if (cnt_q == 5'd1) begin
          out_d    = st_dec;
          en_out_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      st_q     <= '0;
      kreg_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      en_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      kreg_q   <= kreg_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      en_out_q <= en_out_d;
    end
  end

  assign out        = out_q;
  assign enable_out = en_out_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: doc/present_decrypt.md
# present_decrypt

Iterative PRESENT-80 decryption core: one inverse round per clock using the inverse bit permutation, the inverse S-box layer and an on-the-fly reversed key schedule. It is the receive-side counterpart of the encryption datapath and shares its 64-bit state, 80-bit key and `enable_in`/`enable_out` conventions. A start pulse loads a ciphertext and user key. After a fixed latency the core returns the plaintext with a one-cycle `enable_out` strobe.

## Interface
- No parameters; block width is fixed: 64-bit state, 80-bit key, 31 rounds.
- One clock; reset is asynchronous and active-low.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable_in` in 1: start request, sampled only in IDLE.
- `ciphertext` in 64: block to decrypt; sampled with `enable_in`.
- `key` in 80: user key, `key[79]` is MSB; sampled with `enable_in`.
- `out` out 64: plaintext; holds its value until the next completion.
- `enable_out` out 1: one-cycle strobe; `out` is valid while it is high.
- `busy` out 1: high while an operation is in progress.

## Operation
- Bit 0 is the LSB throughout.
- Forward permutation: P(i) = 16·i mod 63 for i < 63, and P(63) = 63.
- Inverse permutation: `ip[j] = s[P(j)]`.
- Inverse S-box, nibble-wise, for inputs 0..F: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- Forward key update with round counter c:
  - rotate the 80-bit register left 61;
  - apply the forward S-box (C56B90AD3EF84712) to [79:76];
  - XOR c into [19:15].
- Reverse key update with counter c: undo the forward update in reverse order.
  - XOR c into [19:15];
  - apply the inverse S-box to [79:76];
  - rotate left 19.
- Round key is `kreg[79:16]`.
- FSM states: IDLE, KEYFWD, WHITEN, DECRYPT.
- IDLE:
  - On `enable_in`=1: load `kreg`←`key`, `st`←`ciphertext`, `cnt`←1, go to KEYFWD.
  - Otherwise stay in IDLE.
- KEYFWD: each cycle apply the forward key update with `cnt`, then `cnt`++. When `cnt`=31, after that update `kreg` holds K32; go to WHITEN.
- WHITEN: `st`←`st` ^ `kreg[79:16]`, `cnt`←31, go to DECRYPT.
- DECRYPT, each cycle:
  - `k'` = reverse-update(`kreg`, `cnt`);
  - `st`←invS(invP(`st`)) ^ `k'`[79:16];
  - `kreg`←`k'`, `cnt`--.
- DECRYPT exit: the cycle with `cnt`=1 writes the result to `out`, pulses `enable_out`, and returns to IDLE.
- `cnt` is 5 bits. It never wraps; values 0 and 32+ are unreachable.
- `enable_in` is ignored while `busy`=1. No queuing, no error flag.

## Timing
- Reset values:
  - `out`=0, `enable_out`=0, `busy`=0;
  - FSM in IDLE;
  - `st`, `kreg`, `cnt` = 0.
- Asserting reset mid-operation aborts immediately. No `enable_out` is produced and `out` returns to 0.
- Edge numbering: E0 is the rising edge that samples `enable_in`=1 in IDLE.
- KEYFWD occupies E1..E31, WHITEN is E32, DECRYPT occupies E33..E63.
- `busy` is high from after E0 until after E63.
- `enable_out` rises after E63 and falls after E64. Latency is 63 cycles.
- `out` updates only at E63.
- A new `enable_in` sampled at E64, while `enable_out` is still high, is accepted. Back-to-back throughput is one block per 64 cycles.
- No combinational path from any input to any output.

## Configuration
- `PRESENT_DECKEY_IN_EN`, when defined:
  - `key` is interpreted as the precomputed final key register K32;
  - IDLE goes straight to WHITEN, and KEYFWD logic is not built;
  - latency is 32 cycles (WHITEN at E1, DECRYPT at E2..E32).
- When undefined: the user key is expanded in KEYFWD, with latency 63 as specified above.

## Test plan
- Decrypt with `key`=0, `ciphertext`=5579C1387B228445 → `out`=0000000000000000, `enable_out` one cycle, exactly 63 cycles after E0.
- Decrypt with `key`=FFFF…FF, `ciphertext`=E72C46C0F5945049 → `out`=0000000000000000.
- Decrypt with `key`=0, `ciphertext`=A112FFC72F68417B → `out`=FFFFFFFFFFFFFFFF. Then immediately decrypt with `key`=FFFF…FF, `ciphertext`=3333DCD3213210D2 (`enable_in` at E64) → `out`=FFFFFFFFFFFFFFFF after a further 63 cycles.
- Pulse `enable_in` with different data at E10 and E40 of a running operation → ignored; the first result is unchanged and only one `enable_out` is produced.
- Assert `reset_n`=0 at E20 → `busy`, `enable_out` and `out` all go to 0 asynchronously. After release, a fresh vector-1 run yields the correct result.
- With `PRESENT_DECKEY_IN_EN`: set `key` to the K32 of the all-zero user key and `ciphertext`=5579C1387B228445 → `out`=0 after 32 cycles.
